arb: RTL and testbench



---
 rtl/arb.sv | 88 ++++++++
 tb/tb_arb.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/arb.sv
`default_nettype none
// ============================================================================
// Module   : arb
// Purpose  : Two-requester bus arbiter. It grants a shared bus to either the
//            DMA engine or the TDSP core, one owner at a time. TDSP wins a
//            simultaneous request from IDLE. The owner keeps the bus until it
//            drops its request. When the owner releases the bus while the
//            other master is waiting, the bus passes straight to the waiting
//            master with no dead cycles. The two state flops can be put into
//            the DFT scan chain.
// Ports    : clk        in   rising-edge system clock
//            reset      in   asynchronous active-high reset
//            dma_breq   in   DMA bus request (level)
//            dma_grant  out  DMA owns the bus (decoded from state flops)
//            tdsp_breq  in   TDSP bus request (level)
//            tdsp_grant out  TDSP owns the bus (decoded from state flops)
//            scan_in0   in   scan chain serial input
//            scan_en    in   scan shift enable (0 = functional)
//            scan_out0  out  scan chain serial output (state[1])
// Revision : 1.0 - initial release
// ============================================================================
module arb (
  input  logic clk,
  input  logic reset,
  input  logic dma_breq,
  output logic dma_grant,
  input  logic tdsp_breq,
  output logic tdsp_grant,
  input  logic scan_in0,
  input  logic scan_en,
  output logic scan_out0
);

  localparam logic [1:0] ST_IDLE     = 2'b00;
  localparam logic [1:0] ST_GNT_DMA  = 2'b01;
  localparam logic [1:0] ST_GNT_TDSP = 2'b10;

  logic [1:0] state_q;
  logic [1:0] state_d;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. In scan mode the two flops become a shift register:
  // scan_in0 -> state[0] -> state[1] -> scan_out0. The 11 encoding is not a
  // legal state, so it falls back to IDLE.
  always_comb begin
    state_d = ST_IDLE;
    if (scan_en) begin
      state_d = {state_q[0], scan_in0};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tdsp_breq)     state_d = ST_GNT_TDSP;
          else if (dma_breq) state_d = ST_GNT_DMA;
          else               state_d = ST_IDLE;
        end
        ST_GNT_DMA: begin
          if (dma_breq)       state_d = ST_GNT_DMA;
          else if (tdsp_breq) state_d = ST_GNT_TDSP;
          else                state_d = ST_IDLE;
        end
        ST_GNT_TDSP: begin
          if (tdsp_breq)     state_d = ST_GNT_TDSP;
          else if (dma_breq) state_d = ST_GNT_DMA;
          else               state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output decode. Both grants are full-code compares, so the two grants can
  // never be high together, even if scan loads the 11 code.
  always_comb begin
    dma_grant  = (state_q == ST_GNT_DMA);
    tdsp_grant = (state_q == ST_GNT_TDSP);
    scan_out0  = state_q[1];
  end

endmodule
`default_nettype wire

// File: tb/tb_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_arb
// Purpose  : Directed self-checking bench for arb. It also runs a randomised
//            fairness run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arb;

  logic clk = 1'b0;
  logic reset;
  logic dma_breq, tdsp_breq;
  logic dma_grant, tdsp_grant;
  logic scan_in0, scan_en, scan_out0;

  int n_checks = 0;
  int n_fail   = 0;

  arb dut (
    .clk        (clk),
    .reset      (reset),
    .dma_breq   (dma_breq),
    .dma_grant  (dma_grant),
    .tdsp_breq  (tdsp_breq),
    .tdsp_grant (tdsp_grant),
    .scan_in0   (scan_in0),
    .scan_en    (scan_en),
    .scan_out0  (scan_out0)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Fairness run bookkeeping. Per-requester phase: 0 wait, 1 requesting,
  // 2 granted (drop next cycle), 3 done.
  int d_ph, t_ph, d_dly, t_dly;
  int d_cnt, t_cnt, overlap, timeouts, cyc;
  logic d_prev, t_prev;

  initial begin
    reset     = 1'b1;
    dma_breq  = 1'b1;
    tdsp_breq = 1'b1;
    scan_in0  = 1'b0;
    scan_en   = 1'b0;

    // ---- Reset held 3 cycles with both requests high ----
    #1;
    check("rst_dma_grant", dma_grant, 1'b0);
    check("rst_tdsp_grant", tdsp_grant, 1'b0);
    tick(); tick(); tick();
    check("rst3_dma_grant", dma_grant, 1'b0);
    check("rst3_tdsp_grant", tdsp_grant, 1'b0);
    check("rst3_scan_out0", scan_out0, 1'b0);
    reset = 1'b0;
    tick();
    check("prio_tdsp_grant", tdsp_grant, 1'b1);
    check("prio_dma_grant", dma_grant, 1'b0);
    dma_breq  = 1'b0;
    tdsp_breq = 1'b0;
    tick();
    check("rel_tdsp_grant", tdsp_grant, 1'b0);
    check("rel_dma_grant", dma_grant, 1'b0);

    // ---- Single DMA request ----
    repeat (5) tick();
    dma_breq = 1'b1;
    tick();
    check("dma_single_grant", dma_grant, 1'b1);
    tick();
    check("dma_hold_grant", dma_grant, 1'b1);
    dma_breq = 1'b0;
    tick();
    check("dma_rel_grant", dma_grant, 1'b0);
    check("dma_rel_tdsp", tdsp_grant, 1'b0);
    check("dma_rel_state1", scan_out0, 1'b0);

    // ---- Handoff DMA -> TDSP ----
    dma_breq = 1'b1;
    tick();
    check("h1_dma_grant", dma_grant, 1'b1);
    tdsp_breq = 1'b1;
    tick();
    check("h1_nopreempt_dma", dma_grant, 1'b1);
    check("h1_nopreempt_tdsp", tdsp_grant, 1'b0);
    tick();
    check("h1_wait_tdsp", tdsp_grant, 1'b0);
    dma_breq = 1'b0;
    tick();
    check("h1_dma_fall", dma_grant, 1'b0);
    check("h1_tdsp_rise", tdsp_grant, 1'b1);
    check("h1_state1", scan_out0, 1'b1);

    // ---- Handoff TDSP -> DMA ----
    dma_breq = 1'b1;
    tick();
    check("h2_tdsp_hold", tdsp_grant, 1'b1);
    check("h2_dma_wait", dma_grant, 1'b0);
    tdsp_breq = 1'b0;
    tick();
    check("h2_tdsp_fall", tdsp_grant, 1'b0);
    check("h2_dma_rise", dma_grant, 1'b1);
    dma_breq = 1'b0;
    tick();
    check("h2_idle_dma", dma_grant, 1'b0);
    check("h2_idle_tdsp", tdsp_grant, 1'b0);

    // ---- Asynchronous reset in the middle of a grant ----
    dma_breq = 1'b1;
    tick();
    check("ar_dma_grant", dma_grant, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("ar_dma_drop", dma_grant, 1'b0);
    #1 reset = 1'b0;
    tick();
    check("ar_dma_regrant", dma_grant, 1'b1);
    dma_breq = 1'b0;
    tick();
    check("ar_idle", dma_grant, 1'b0);

    // ---- Random fairness: 256 paired request episodes ----
    d_cnt = 0; t_cnt = 0; overlap = 0; timeouts = 0;
    d_prev = 1'b0; t_prev = 1'b0;
    for (int ep = 0; ep < 256; ep++) begin
      d_ph = 0; t_ph = 0;
      d_dly = $urandom_range(0, 31);
      t_dly = $urandom_range(0, 31);
      cyc = 0;
      while (!(d_ph == 3 && t_ph == 3 && !dma_grant && !tdsp_grant)) begin
        if (cyc > 200) begin
          timeouts++;
          break;
        end
        // DMA requester
        if (d_ph == 0) begin
          if (d_dly == 0) begin dma_breq = 1'b1; d_ph = 1; end
          else d_dly--;
        end else if (d_ph == 2) begin
          dma_breq = 1'b0; d_ph = 3;
        end
        // TDSP requester
        if (t_ph == 0) begin
          if (t_dly == 0) begin tdsp_breq = 1'b1; t_ph = 1; end
          else t_dly--;
        end else if (t_ph == 2) begin
          tdsp_breq = 1'b0; t_ph = 3;
        end
        tick();
        cyc++;
        if (dma_grant && tdsp_grant) overlap++;
        if (dma_grant && !d_prev) d_cnt++;
        if (tdsp_grant && !t_prev) t_cnt++;
        d_prev = dma_grant;
        t_prev = tdsp_grant;
        if (d_ph == 1 && dma_grant)  d_ph = 2;
        if (t_ph == 1 && tdsp_grant) t_ph = 2;
      end
      dma_breq  = 1'b0;
      tdsp_breq = 1'b0;
    end
    check_int("fair_dma_grants", d_cnt, 256);
    check_int("fair_tdsp_grants", t_cnt, 256);
    check_int("fair_both_high", overlap, 0);
    check_int("fair_timeouts", timeouts, 0);
    repeat (2) tick();

    // ---- Scan shift: 1 then 0 ----
    scan_en  = 1'b1;
    scan_in0 = 1'b1;
    tick();
    check("scan1_out", scan_out0, 1'b0);
    check("scan1_dma", dma_grant, 1'b1);
    scan_in0 = 1'b0;
    tick();
    check("scan2_out", scan_out0, 1'b1);
    check("scan2_tdsp", tdsp_grant, 1'b1);
    // Resume from the shifted GNT_TDSP state: a pending DMA takes over.
    scan_en  = 1'b0;
    dma_breq = 1'b1;
    tick();
    check("scan_resume_dma", dma_grant, 1'b1);
    check("scan_resume_tdsp", tdsp_grant, 1'b0);
    dma_breq = 1'b0;
    tick();
    check("scan_resume_idle", dma_grant, 1'b0);

    // ---- Scan loads the illegal 11 code; it must return to IDLE ----
    scan_en  = 1'b1;
    scan_in0 = 1'b1;
    tick();
    tick();
    check("ill_out", scan_out0, 1'b1);
    check("ill_dma", dma_grant, 1'b0);
    check("ill_tdsp", tdsp_grant, 1'b0);
    scan_en   = 1'b0;
    scan_in0  = 1'b0;
    dma_breq  = 1'b1;
    tdsp_breq = 1'b1;
    tick();
    check("ill_to_idle_dma", dma_grant, 1'b0);
    check("ill_to_idle_tdsp", tdsp_grant, 1'b0);
    check("ill_to_idle_out", scan_out0, 1'b0);
    tick();
    check("ill_then_tdsp", tdsp_grant, 1'b1);
    dma_breq  = 1'b0;
    tdsp_breq = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
